prbs7_checker: RTL and testbench

// - Receive-side PRBS-7 (x^7+x^6+1) checker for a WIDTH-bit parallel word stream, one word per enabled clock.
// - Self-synchronises to the incoming stream, then free-runs a local reference and reports bit errors per word.
// - Companion of prbs_wide_generate (TX side) in the BER tester; both share one next-word function.

---
 rtl/prbs_pkg.sv | 38 +++
 rtl/prbs7_ref_gen.sv | 13 +
 rtl/prbs_wide_generate.sv | 34 +++
 rtl/prbs7_checker.sv | 119 +++++++++++
 tb/tb_prbs7_checker.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS-7 constants, checker state type and shared word/popcount helpers
package prbs_pkg;

  localparam int PRBS_ORDER = 7;
  localparam int POLY_TAPS [2] = '{7, 6};
  localparam int MAX_WIDTH = 64;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } chk_state_e;

  // seed[0] is the oldest of the last 7 stream bits; bit 0 of the result is the next serial bit
  function automatic logic [MAX_WIDTH-1:0] prbs7_next_word(input logic [PRBS_ORDER-1:0] seed);
    logic [PRBS_ORDER-1:0] s;
    logic                  nb;
    logic [MAX_WIDTH-1:0]  w;
    s = seed;
    w = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      nb   = s[PRBS_ORDER-POLY_TAPS[0]] ^ s[PRBS_ORDER-POLY_TAPS[1]];
      w[i] = nb;
      s    = {nb, s[PRBS_ORDER-1:1]};
    end
    return w;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs7_ref_gen.sv
// rtl/prbs7_ref_gen.sv - combinational PRBS-7 next-word predictor
module prbs7_ref_gen
  import prbs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [PRBS_ORDER-1:0] seed_i,
  output logic [WIDTH-1:0]      next_o
);

  assign next_o = WIDTH'(prbs7_next_word(seed_i));

endmodule

// File: rtl/prbs_wide_generate.sv
// rtl/prbs_wide_generate.sv - PRBS-7 parallel word generator, WIDTH serial bits per enabled clock
module prbs_wide_generate
  import prbs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] prbs
);

  logic [PRBS_ORDER-1:0] state_q;
  logic [WIDTH-1:0]      prbs_q;
  logic [WIDTH-1:0]      word_next;

  prbs7_ref_gen #(.WIDTH(WIDTH)) u_ref_gen (
    .seed_i (state_q),
    .next_o (word_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= 7'h7F;
      prbs_q  <= '0;
    end else if (en) begin
      prbs_q  <= word_next;
      state_q <= word_next[WIDTH-1 -: PRBS_ORDER];
    end
  end

  assign prbs = prbs_q;

endmodule

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising PRBS-7 checker with flywheel reference and per-word error count
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] prbs,
  output logic             lock,
  output logic [WIDTH:0]   err_num
);

  localparam int ERR_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] LOCK_TH   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_TH = CNT_W'(UNLOCK_CNT);

  chk_state_e            state_q, state_d;
  // only the newest 7 bits of the previous/reference word determine the prediction
  logic [PRBS_ORDER-1:0] prev_q, prev_d;
  logic [PRBS_ORDER-1:0] ref_q, ref_d;
  logic [CNT_W-1:0]      good_q, good_d;
  logic [CNT_W-1:0]      bad_q, bad_d;
  logic                  first_q, first_d;
  logic                  lock_q, lock_d;
  logic [ERR_W-1:0]      err_q, err_d;

  logic [PRBS_ORDER-1:0] seed;
  logic [WIDTH-1:0]      exp_word;
  logic [ERR_W-1:0]      err_calc;

  assign seed = (state_q == ST_LOCKED) ? ref_q : prev_q;

  prbs7_ref_gen #(.WIDTH(WIDTH)) u_ref_gen (
    .seed_i (seed),
    .next_o (exp_word)
  );

  assign err_calc = ERR_W'(popcount(MAX_WIDTH'(prbs ^ exp_word)));

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    ref_d   = ref_q;
    good_d  = good_q;
    bad_d   = bad_q;
    first_d = first_q;
    lock_d  = lock_q;
    err_d   = err_q;
    if (en) begin
      prev_d = prbs[WIDTH-1 -: PRBS_ORDER];
      case (state_q)
        ST_UNLOCKED: begin
          err_d = '0;
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            // all-zero word is the LFSR lock-up state and must never build lock
            if ((prbs == exp_word) && (prbs != '0)) begin
              good_d = (good_q == LOCK_TH) ? good_q : good_q + 1'b1;
            end else begin
              good_d = '0;
            end
            if (good_d == LOCK_TH) begin
              state_d = ST_LOCKED;
              lock_d  = 1'b1;
              ref_d   = prbs[WIDTH-1 -: PRBS_ORDER];
              bad_d   = '0;
            end
          end
        end
        ST_LOCKED: begin
          ref_d = exp_word[WIDTH-1 -: PRBS_ORDER];
          err_d = err_calc;
          if (err_calc != '0) begin
            bad_d = (bad_q == UNLOCK_TH) ? bad_q : bad_q + 1'b1;
          end else begin
            bad_d = '0;
          end
          if (bad_d == UNLOCK_TH) begin
            state_d = ST_UNLOCKED;
            lock_d  = 1'b0;
            good_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_UNLOCKED;
      prev_q  <= '0;
      ref_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      first_q <= 1'b1;
      lock_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      ref_q   <= ref_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      first_q <= first_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign lock    = lock_q;
  assign err_num = err_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - directed bench for prbs_wide_generate and prbs7_checker
module tb_prbs7_checker;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         gen_en = 1'b0;
  logic         chk_en = 1'b0;
  logic         sel_gen = 1'b0;
  logic [W-1:0] flip = '0;
  logic [W-1:0] man_word = '0;
  logic [W-1:0] gen_prbs;
  logic [W-1:0] chk_data;
  logic         lock;
  logic [W:0]   err_num;

  int total = 0;
  int bad = 0;
  bit stream[$];

  always #5 clk = ~clk;

  assign chk_data = sel_gen ? (gen_prbs ^ flip) : man_word;

  prbs_wide_generate #(.WIDTH(W)) u_gen (
    .clk   (clk),
    .reset (rst_n),
    .en    (gen_en),
    .prbs  (gen_prbs)
  );

  prbs7_checker #(.WIDTH(W), .LOCK_CNT(4), .UNLOCK_CNT(4)) u_dut (
    .clk     (clk),
    .reset   (rst_n),
    .en      (chk_en),
    .prbs    (chk_data),
    .lock    (lock),
    .err_num (err_num)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    gen_en = 1'b0;
    chk_en = 1'b0;
    flip   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // stream[n+7] is serial bit b[n]; the seven leading ones are the generator's reset history
  function automatic logic [W-1:0] model_word(input int k);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = stream[7 + k*W + i];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int n = 0; n < 7; n++) stream.push_back(1'b1);
    for (int n = 7; n < 7 + W*140; n++) stream.push_back(stream[n-7] ^ stream[n-6]);

    #1 rst_n = 1'b0;
    #1;
    check("rst_lock", lock, 0);
    check("rst_err", err_num, 0);
    check("rst_gen", gen_prbs, 0);
    tick();
    tick();
    rst_n = 1'b1;

    gen_en = 1'b1;
    for (int k = 0; k < 128; k++) begin
      tick();
      check("gen_word", gen_prbs, model_word(k));
      check("gen_nonzero", gen_prbs != '0, 1);
      if (k == 0)   check("gen_first", gen_prbs, 8'h40);
      if (k == 1)   check("gen_second", gen_prbs, 8'h30);
      if (k == 127) check("gen_period", gen_prbs, 8'h40);
    end

    do_reset();
    sel_gen = 1'b1;
    gen_en  = 1'b1;
    chk_en  = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check("lock_seq", lock, (n >= 6) ? 1 : 0);
      check("lock_err", err_num, 0);
    end

    flip = 8'h10;
    tick();
    check("flip1_err", err_num, 1);
    check("flip1_lock", lock, 1);
    flip = 8'h0B;
    tick();
    check("flip3_err", err_num, 3);
    check("flip3_lock", lock, 1);
    flip = '0;
    tick();
    check("clean_err", err_num, 0);
    check("clean_lock", lock, 1);

    gen_en = 1'b0;
    tick();
    check("hold0_err", err_num, 0);
    check("hold0_lock", lock, 1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("hold_err_nz", err_num != '0, 1);
      check("hold_lock", lock, (j < 4) ? 1 : 0);
    end
    gen_en = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("relock_lock", lock, (j == 5) ? 1 : 0);
      check("relock_err", err_num, 0);
    end
    tick();
    check("relocked_err", err_num, 0);
    check("relocked_lock", lock, 1);

    flip = 8'h01;
    tick();
    check("pre_freeze_err", err_num, 1);
    chk_en = 1'b0;
    flip   = 8'hFF;
    tick();
    tick();
    check("freeze_err", err_num, 1);
    check("freeze_lock", lock, 1);

    #3 rst_n = 1'b0;
    #1;
    check("async_rst_lock", lock, 0);
    check("async_rst_err", err_num, 0);
    tick();
    rst_n  = 1'b1;
    flip   = '0;
    gen_en = 1'b0;

    sel_gen  = 1'b0;
    man_word = '0;
    chk_en   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("zero_lock", lock, 0);
      check("zero_err", err_num, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
